// File: rtl/fifo_async_pkg.sv
// Shared definitions for the FIFO_Async family: safe clog2 and parameter sanity checks.
package fifo_async_pkg;

    localparam int MIN_WIDTH       = 1;
    localparam int MIN_RD_LAT      = 1;
    localparam int MIN_SKID_MARGIN = 2;

    // Pointer width that never collapses to zero bits for tiny depths.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // The skid buffer must hold the head word, the word in capture and every in-flight read.
    function automatic bit skid_depth_ok(input int rdLat, input int depth);
        return depth >= rdLat + MIN_SKID_MARGIN;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Register ring holding words captured from the FIFO read port until the consumer takes them.
module stream_skid_buf
    import fifo_async_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_Push,
    input  logic [WIDTH-1:0]             i_PushData,
    input  logic                         i_Pop,
    input  logic                         i_Flush,
    output logic                         o_Valid,
    output logic [WIDTH-1:0]             o_Data,
    output logic [$clog2(DEPTH+1)-1:0]   o_Level
);

    localparam int PTR_W = clog2_safe(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_Mem [DEPTH];
    logic [PTR_W-1:0] r_Head;
    logic [PTR_W-1:0] r_Tail;
    logic [LVL_W-1:0] r_Level;
    logic             w_Push;
    logic             w_Pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Flush wins over both push and pop so nothing survives the flush edge.
    assign w_Pop  = i_Pop && (r_Level != '0) && !i_Flush;
    assign w_Push = i_Push && !i_Flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_Head  <= '0;
            r_Tail  <= '0;
            r_Level <= '0;
        end else if (i_Flush) begin
            r_Head  <= '0;
            r_Tail  <= '0;
            r_Level <= '0;
        end else begin
            if (w_Push) r_Tail <= ptr_next(r_Tail);
            if (w_Pop)  r_Head <= ptr_next(r_Head);
            case ({w_Push, w_Pop})
                2'b10:   r_Level <= r_Level + 1'b1;
                2'b01:   r_Level <= r_Level - 1'b1;
                default: r_Level <= r_Level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_Push) r_Mem[r_Tail] <= i_PushData;
    end

    assign o_Valid = (r_Level != '0);
    assign o_Data  = o_Valid ? r_Mem[r_Head] : '0;
    assign o_Level = r_Level;

    // Credit accounting upstream guarantees a free slot for every capture.
    a_noFullPush: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(w_Push && (r_Level == LVL_W'(DEPTH))));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: turns the FIFO_Async enable/empty port into a valid/ready stream.
module fifo_rd_stream
    import fifo_async_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int RD_LAT     = 1,
    parameter int SKID_DEPTH = 3
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    output logic                              o_RD_En,
    input  logic                              i_Empty,
    input  logic [WIDTH-1:0]                  i_RD_Data,
    input  logic                              i_Flush,
    output logic                              o_Valid,
    input  logic                              i_Ready,
    output logic [WIDTH-1:0]                  o_Data,
    output logic [$clog2(SKID_DEPTH+1)-1:0]   o_Level
);

    localparam int LVL_W = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W = $clog2(SKID_DEPTH + RD_LAT + 1);

    if (!skid_depth_ok(RD_LAT, SKID_DEPTH)) begin : g_depthCheck
        $error("fifo_rd_stream: SKID_DEPTH must be at least RD_LAT+2");
    end
    if (RD_LAT < MIN_RD_LAT || WIDTH < MIN_WIDTH) begin : g_paramCheck
        $error("fifo_rd_stream: RD_LAT and WIDTH must be at least 1");
    end

    logic              r_Run;
    logic [RD_LAT:1]   r_Pipe;
    logic [OCC_W-1:0]  w_InFlight;
    logic [OCC_W-1:0]  w_Occ;
    logic [LVL_W-1:0]  w_Level;
    logic              w_RdEn;

    always_comb begin
        w_InFlight = '0;
        for (int k = 1; k <= RD_LAT; k++) begin
            w_InFlight = w_InFlight + OCC_W'(r_Pipe[k]);
        end
    end

    // Issue only when every outstanding read already has a reserved slot.
    assign w_Occ   = w_InFlight + OCC_W'(w_Level);
    assign w_RdEn  = r_Run && !i_Empty && !i_Flush && (w_Occ < OCC_W'(SKID_DEPTH));
    assign o_RD_En = w_RdEn;
    assign o_Level = w_Level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_Run  <= 1'b0;
            r_Pipe <= '0;
        end else begin
            r_Run <= 1'b1;
            if (i_Flush) begin
                r_Pipe <= '0;
            end else begin
                r_Pipe[1] <= w_RdEn;
                for (int k = 2; k <= RD_LAT; k++) begin
                    r_Pipe[k] <= r_Pipe[k-1];
                end
            end
        end
    end

    stream_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skidBuf (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_Push     (r_Pipe[RD_LAT]),
        .i_PushData (i_RD_Data),
        .i_Pop      (i_Ready),
        .i_Flush    (i_Flush),
        .o_Valid    (o_Valid),
        .o_Data     (o_Data),
        .o_Level    (w_Level)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream driven by a behavioural FIFO_Async (DEPTH=3, RD_LAT=1).
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rstN;
    logic       rdEn;
    logic       fifoEmpty;
    logic [7:0] rdData = '0;
    logic       iFlush;
    logic       oValid;
    logic       iReady;
    logic [7:0] oData;
    logic [1:0] oLevel;

    logic [7:0] fMem [0:2];
    int         fWr = 0;
    int         fRd = 0;
    int         fCnt = 0;
    logic [7:0] pendQ [$];
    logic [7:0] gotQ [$];
    logic [7:0] expQ [$];

    int vectors = 0;
    int miscompares = 0;
    int firstIdx;
    int lastIdx;
    int nValid;

    always #5 clk = ~clk;

    fifo_rd_stream #(.WIDTH(8), .RD_LAT(1), .SKID_DEPTH(3)) dut (
        .i_clk     (clk),
        .i_rst_n   (rstN),
        .o_RD_En   (rdEn),
        .i_Empty   (fifoEmpty),
        .i_RD_Data (rdData),
        .i_Flush   (iFlush),
        .o_Valid   (oValid),
        .i_Ready   (iReady),
        .o_Data    (oData),
        .o_Level   (oLevel)
    );

    // Behavioural FIFO: one-clock read latency, writer refills from pendQ at one word per clock.
    assign fifoEmpty = (fCnt == 0);

    always @(posedge clk) begin
        automatic int cnt = fCnt;
        if (rdEn && fCnt > 0) begin
            rdData <= fMem[fRd];
            fRd    <= (fRd + 1) % 3;
            cnt    = cnt - 1;
        end
        if (pendQ.size() > 0 && fCnt < 3) begin
            fMem[fWr] <= pendQ.pop_front();
            fWr       <= (fWr + 1) % 3;
            cnt       = cnt + 1;
        end
        fCnt <= cnt;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic flush);
        @(negedge clk);
        iReady = ready;
        iFlush = flush;
        #1;
        if (oValid && iReady && !iFlush && rstN) gotQ.push_back(oData);
    endtask

    task automatic pushWords(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) pendQ.push_back(first + 8'(i));
    endtask

    task automatic checkSequence(input string tag, input logic [7:0] first, input int n);
        checkOutput({tag, "_count"}, gotQ.size(), n);
        for (int i = 0; i < n && i < gotQ.size(); i++)
            checkOutput($sformatf("%s_word%0d", tag, i), gotQ[i], first + 8'(i));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN   = 1'b1;
        iReady = 1'b1;
        iFlush = 1'b0;
        #2 rstN = 1'b0;
        pendQ.push_back(8'hAB);

        // Reset state, with a word already waiting in the FIFO
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_valid", oValid, 0);
        checkOutput("rst_data", oData, 0);
        checkOutput("rst_level", oLevel, 0);
        checkOutput("rst_rden", rdEn, 0);
        rstN = 1'b1;
        #1;
        checkOutput("rden_before_run", rdEn, 0);

        // Test 1: single word
        applyStimulus(1, 0);
        checkOutput("t1_rden_on", rdEn, 1);
        checkOutput("t1_valid_early", oValid, 0);
        applyStimulus(1, 0);
        checkOutput("t1_rden_off", rdEn, 0);
        checkOutput("t1_valid_inflight", oValid, 0);
        applyStimulus(1, 0);
        checkOutput("t1_valid", oValid, 1);
        checkOutput("t1_data", oData, 8'hAB);
        checkOutput("t1_level", oLevel, 1);
        applyStimulus(1, 0);
        checkOutput("t1_valid_done", oValid, 0);
        checkSequence("t1", 8'hAB, 1);

        // Test 2: stream with consumer always ready
        gotQ.delete();
        pushWords(8'h40, 8);
        firstIdx = -1; lastIdx = -1; nValid = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1, 0);
            if (oValid) begin
                nValid++;
                if (firstIdx < 0) firstIdx = c;
                lastIdx = c;
            end
        end
        checkOutput("t2_span", lastIdx - firstIdx + 1, 8);
        checkOutput("t2_nvalid", nValid, 8);
        checkSequence("t2", 8'h40, 8);

        // Test 3: backpressure fills the skid buffer
        gotQ.delete();
        pushWords(8'h40, 8);
        repeat (10) applyStimulus(0, 0);
        checkOutput("t3_level_full", oLevel, 3);
        checkOutput("t3_rden_off", rdEn, 0);
        checkOutput("t3_valid", oValid, 1);
        checkOutput("t3_data_held", oData, 8'h40);
        repeat (20) applyStimulus(1, 0);
        checkSequence("t3", 8'h40, 8);

        // Test 4: flush with two stored and one in flight; 52 is dropped
        gotQ.delete();
        pushWords(8'h50, 8);
        repeat (3) applyStimulus(0, 0);
        applyStimulus(0, 1);
        checkOutput("t4_level_pre", oLevel, 2);
        checkOutput("t4_rden_flush", rdEn, 0);
        applyStimulus(0, 0);
        checkOutput("t4_valid_post", oValid, 0);
        checkOutput("t4_level_post", oLevel, 0);
        repeat (20) applyStimulus(1, 0);
        checkSequence("t4", 8'h53, 5);

        // Test 5: reset while draining; stored 61 and in-flight 62 are lost
        gotQ.delete();
        pushWords(8'h60, 8);
        repeat (4) applyStimulus(1, 0);
        checkOutput("t5_valid_before", oValid, 1);
        rstN = 1'b0;
        #1;
        checkOutput("t5_rst_valid", oValid, 0);
        checkOutput("t5_rst_data", oData, 0);
        checkOutput("t5_rst_level", oLevel, 0);
        checkOutput("t5_rst_rden", rdEn, 0);
        gotQ.delete();
        repeat (2) applyStimulus(1, 0);
        checkOutput("t5_rden_in_reset", rdEn, 0);
        rstN = 1'b1;
        #1;
        checkOutput("t5_rden_release", rdEn, 0);
        applyStimulus(1, 0);
        checkOutput("t5_rden_run", rdEn, 1);
        repeat (20) applyStimulus(1, 0);
        checkSequence("t5", 8'h63, 5);

        // Test 6: random consumer readiness over 200 words
        gotQ.delete();
        for (int i = 0; i < 200; i++) begin
            pendQ.push_back(8'(i * 37 + 5));
            expQ.push_back(8'(i * 37 + 5));
        end
        for (int c = 0; c < 3000 && gotQ.size() < 200; c++)
            applyStimulus(1'($urandom_range(0, 1)), 0);
        repeat (10) applyStimulus(1, 0);
        checkOutput("t6_count", gotQ.size(), 200);
        checkOutput("t6_level_end", oLevel, 0);
        for (int i = 0; i < 200 && i < gotQ.size(); i++)
            checkOutput($sformatf("t6_word%0d", i), gotQ[i], expQ[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
